// File: rtl/gcd_sequencer.sv
// Host-facing controller for one binary GCD engine: accepts operand pairs, runs the
// engine with a timeout guard, short-circuits zero operands, and returns the result.
module gcd_sequencer #(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 32,
   parameter int CNT_W   = 6
) (
   input  logic             clk,
   input  logic             resetb,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_u,
   input  logic [WIDTH-1:0] in_v,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_res,
   output logic             out_err,
   output logic [CNT_W-1:0] out_cycles,
   output logic             eng_ld,
   output logic [WIDTH-1:0] eng_u,
   output logic [WIDTH-1:0] eng_v,
   input  logic             eng_done,
   input  logic [WIDTH-1:0] eng_res,
   output logic             busy,
   output logic [1:0]       state_dbg
);

   // Handshakes: a transfer happens on a rising clk edge where valid && ready are both 1;
   // the source holds valid and data stable until that edge, and ready never waits on valid.

   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

   localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic [WIDTH-1:0] op_u, op_v;
   logic             accept, zero_op, timeout_hit;

   assign accept      = in_valid && in_ready;
   assign zero_op     = (in_u == '0) || (in_v == '0);
   assign cnt_inc     = cnt + CNT_W'(1);
   assign timeout_hit = (cnt_inc == TMO);

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = zero_op ? RESP : LOAD;
         LOAD: state_nxt = WAIT;
         WAIT: if (eng_done || timeout_hit) state_nxt = RESP;
         RESP: if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      busy      = (state != IDLE);
      eng_ld    = (state == LOAD);
      out_valid = (state == RESP);
      state_dbg = state;
   end

   assign eng_u = op_u;
   assign eng_v = op_v;

   // Operands only change on acceptance, so the engine inputs stay stable through LOAD/WAIT.
   // eng_done is only trusted in WAIT; elsewhere it reflects stale engine state.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         op_u       <= '0;
         op_v       <= '0;
         cnt        <= '0;
         out_res    <= '0;
         out_err    <= 1'b0;
         out_cycles <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_u <= in_u;
                  op_v <= in_v;
                  if (zero_op) begin
                     out_res    <= in_u | in_v;
                     out_err    <= 1'b0;
                     out_cycles <= '0;
                  end
               end
            end
            LOAD: cnt <= '0;
            WAIT: begin
               if (cnt < TMO) cnt <= cnt_inc;
               if (eng_done) begin
                  out_res    <= eng_res;
                  out_err    <= 1'b0;
                  out_cycles <= cnt_inc;
               end else if (timeout_hit) begin
                  out_res    <= '0;
                  out_err    <= 1'b1;
                  out_cycles <= TMO;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gcd_sequencer.sv
// Bench for gcd_sequencer: a behavioural binary GCD engine, directed cases and random
// jobs checked against an arithmetic reference model.
module tb_gcd_sequencer;

   localparam int WIDTH   = 8;
   localparam int TIMEOUT = 16;
   localparam int CNT_W   = 6;

   logic             clk = 1'b0;
   logic             resetb;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_u, in_v;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_res;
   logic             out_err;
   logic [CNT_W-1:0] out_cycles;
   logic             eng_ld;
   logic [WIDTH-1:0] eng_u, eng_v;
   logic             eng_done;
   logic [WIDTH-1:0] eng_res;
   logic             busy;
   logic [1:0]       state_dbg;

   int n_tests = 0;
   int n_fail  = 0;
   int ld_cnt  = 0;
   logic stub  = 1'b0;

   gcd_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .resetb(resetb),
      .in_valid(in_valid), .in_ready(in_ready), .in_u(in_u), .in_v(in_v),
      .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
      .out_err(out_err), .out_cycles(out_cycles),
      .eng_ld(eng_ld), .eng_u(eng_u), .eng_v(eng_v),
      .eng_done(eng_done), .eng_res(eng_res),
      .busy(busy), .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   // behavioural binary GCD engine: one reduction step per cycle, done when u==v
   logic [WIDTH-1:0] eu = '0, ev = '0;
   logic [3:0]       esh = '0;
   always @(posedge clk) begin
      if (eng_ld) begin
         eu <= eng_u; ev <= eng_v; esh <= '0;
      end else if (eu != ev) begin
         if (!eu[0] && !ev[0]) begin eu <= eu >> 1; ev <= ev >> 1; esh <= esh + 1'b1; end
         else if (!eu[0]) eu <= eu >> 1;
         else if (!ev[0]) ev <= ev >> 1;
         else if (eu > ev) eu <= eu - ev;
         else ev <= ev - eu;
      end
   end
   assign eng_done = stub ? 1'b0 : (eu == ev);
   assign eng_res  = eu << esh;

   always @(posedge clk) if (eng_ld) ld_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // reference model: gcd by Euclid, engine cycle count from the binary reduction rules
   task automatic ref_job(input int u, input int v, output int res, output int err, output int cyc);
      int a, b, t, steps;
      if (u == 0 || v == 0) begin
         res = u | v; err = 0; cyc = 0;
         return;
      end
      a = u; b = v;
      while (b != 0) begin t = a % b; a = b; b = t; end
      steps = 0;
      begin
         int x = u, y = v;
         while (x != y) begin
            if (x % 2 == 0 && y % 2 == 0) begin x /= 2; y /= 2; end
            else if (x % 2 == 0) x /= 2;
            else if (y % 2 == 0) y /= 2;
            else if (x > y) x -= y;
            else y -= x;
            steps++;
         end
      end
      if (stub || steps + 1 > TIMEOUT) begin
         res = 0; err = 1; cyc = TIMEOUT;
      end else begin
         res = a; err = 0; cyc = steps + 1;
      end
   endtask

   // driver: called and returns at posedge+1
   task automatic send(input int u, input int v);
      int n = 0;
      in_u = WIDTH'(u); in_v = WIDTH'(v); in_valid = 1'b1;
      while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
      check("accept_wait", n < 100, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic job(input int u, input int v, input int stall, input bit offer);
      int res, err, cyc, edges, ld0;
      ref_job(u, v, res, err, cyc);
      ld0 = ld_cnt;
      out_ready = (stall == 0);
      send(u, v);
      edges = 0;
      while (!out_valid && edges < 200) begin @(posedge clk); #1; edges++; end
      check("resp_wait", edges < 200, 1);
      check("latency", edges, (u == 0 || v == 0) ? 0 : cyc + 1);
      check("out_res", out_res, res);
      check("out_err", out_err, err);
      check("out_cycles", out_cycles, cyc);
      check("ld_pulses", ld_cnt - ld0, (u == 0 || v == 0) ? 0 : 1);
      for (int s = 0; s < stall; s++) begin
         if (offer) begin in_u = 8'd20; in_v = 8'd30; in_valid = 1'b1; end
         @(posedge clk); #1;
         check("stall_valid", out_valid, 1);
         check("stall_res", out_res, res);
         check("stall_in_ready", in_ready, 0);
      end
      check("stall_no_ld", ld_cnt - ld0, (u == 0 || v == 0) ? 0 : 1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("post_valid", out_valid, 0);
      check("post_idle", in_ready, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, in_ready, 1);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_out_err"}, out_err, 0);
      check({tag, "_out_res"}, out_res, 0);
      check({tag, "_out_cycles"}, out_cycles, 0);
      check({tag, "_eng_ld"}, eng_ld, 0);
      check({tag, "_eng_uv"}, {eng_u, eng_v}, 0);
      check({tag, "_state"}, state_dbg, 0);
   endtask

   initial begin
      int ld0;
      resetb = 1'b0; in_valid = 1'b0; in_u = '0; in_v = '0; out_ready = 1'b1;
      #2;
      check_reset_outputs("reset");
      @(negedge clk); resetb = 1'b1;
      @(posedge clk); #1;

      job(12, 18, 0, 0);
      job(7, 7, 0, 0);
      job(0, 45, 0, 0);
      job(0, 0, 0, 0);

      stub = 1'b1;
      job(9, 6, 0, 0);
      check("timeout_busy", busy, 0);
      stub = 1'b0;

      job(48, 36, 10, 1);
      job(20, 30, 0, 0);

      // reset during the second WAIT cycle
      ld0 = ld_cnt;
      send(200, 150);
      @(posedge clk); #1;
      @(posedge clk); #2;
      resetb = 1'b0;
      #1;
      check_reset_outputs("midreset");
      @(negedge clk); resetb = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("midreset_ready", in_ready, 1);
      check("midreset_no_ld", ld_cnt - ld0, 1);
      job(200, 150, 0, 0);

      for (int i = 0; i < 40; i++) begin
         int u, v;
         u = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
         v = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         job(u, v, $urandom_range(0, 3), 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/gcd_sequencer.md
Name: gcd_sequencer

Overview:
- Initiator/controller for the binary GCD engine. It owns the engine's ld/done interface.
- Accepts operand pairs on a valid/ready input, pulses ld to the engine, waits for done, then returns the result on a valid/ready output.
- Handles the operand cases the engine cannot terminate on (zero operands) and guards every job with a timeout.
- Sits between a host request stream and one gcd engine instance.

Parameters:
- WIDTH, 8, operand/result width; must match the engine.
- TIMEOUT, 32, maximum WAIT cycles before a job is aborted (≥2).
- CNT_W, 6, width of the cycle counter and out_cycles; must hold TIMEOUT.

Ports:
- clk  in  1  clock
- resetb  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand pair valid
- in_ready  out  1  sequencer can accept a pair
- in_u  in  WIDTH  operand u
- in_v  in  WIDTH  operand v
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_res  out  WIDTH  gcd result (0 on error)
- out_err  out  1  job timed out
- out_cycles  out  CNT_W  WAIT cycles spent (0 for local bypass)
- eng_ld  out  1  engine load strobe
- eng_u  out  WIDTH  engine operand u
- eng_v  out  WIDTH  engine operand v
- eng_done  in  1  engine done (combinational u_reg==v_reg)
- eng_res  in  WIDTH  engine result
- busy  out  1  state != IDLE

Behaviour:
- Reset is resetb, asynchronous, active-low; clock is clk.
- Reset values:
  - state IDLE, so in_ready=1 and busy=0.
  - out_valid=0, out_err=0, out_res=0, out_cycles=0.
  - eng_ld=0; eng_u/eng_v operand registers = 0.
  - cycle counter = 0.
- States: IDLE, LOAD, WAIT, RESP.
- IDLE:
  - in_ready=1 (combinational: in_ready = state==IDLE; there is no skid buffer).
  - On in_valid&&in_ready, register in_u/in_v into the operand regs.
  - If in_u==0 or in_v==0: go directly to RESP with out_res=in_u|in_v, out_err=0, out_cycles=0. The engine is never loaded in this case, because it never terminates with a zero operand; gcd(0,0)=0.
  - Otherwise go to LOAD.
- LOAD:
  - eng_ld=1 for exactly one cycle; clear the counter; next state WAIT.
  - eng_u/eng_v are driven from the operand regs and held stable from LOAD until leaving WAIT.
- WAIT:
  - eng_ld=0; the counter increments every cycle.
  - eng_done is sampled only in WAIT. It is ignored in IDLE and LOAD, where it reflects stale engine registers.
  - If eng_done=1: out_res<=eng_res, out_err<=0, out_cycles<=counter+1, go to RESP.
  - Else if counter+1==TIMEOUT: out_res<=0, out_err<=1, out_cycles<=TIMEOUT, go to RESP.
  - If eng_done rises on the same cycle the timeout is reached, done wins.
- RESP:
  - out_valid=1; out_res, out_err and out_cycles are held stable until out_ready.
  - On out_valid&&out_ready: out_valid<=0, go to IDLE. A new pair can be accepted on the following cycle.
- Latency:
  - Engine path: 1 cycle IDLE→LOAD, 1 cycle LOAD, N WAIT cycles, then out_valid in the next cycle.
  - Bypass path: out_valid in the cycle after acceptance.
- Reset mid-job: return to IDLE immediately. The pending job and result are discarded, out_valid drops, and no eng_ld is issued after reset.
- in_valid while busy: ignored (in_ready=0); the source must hold it.
- Arithmetic: the counter saturates at TIMEOUT; no wrap.

Test Plan:
- Basic job: (u=12, v=18) with the real engine, out_ready=1.
  - eng_ld pulses once.
  - out_valid arrives with out_res=6, out_err=0, out_cycles=5.
- Equal operands: (7,7).
  - done is seen on the first WAIT cycle; out_res=7, out_cycles=1.
- Zero bypass: (0,45) → out_res=45, out_cycles=0, eng_ld never asserted. Then (0,0) → out_res=0, out_err=0.
- Timeout: stub engine with eng_done tied to 0, TIMEOUT=16, pair (9,6).
  - out_err=1, out_res=0, out_cycles=16.
  - The sequencer returns to IDLE after the handshake.
- Backpressure: (48,36) with out_ready held 0 for 10 cycles.
  - out_valid stays 1 and out_res=12 stays stable; in_ready=0 throughout.
  - A second pair offered during the stall is not accepted until after out_ready.
- Reset mid-WAIT: assert resetb=0 during the 2nd WAIT cycle of (200,150).
  - All outputs go to their reset values asynchronously; in_ready=1 after release.
  - A subsequent (200,150) job returns out_res=50.
